// File: rtl/note_ctrl_pkg.sv
// Shared definitions for the multi-channel note controller: channel FSM
// encoding, default parameter values and a constant-width helper.
package note_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_FREQ_W   = 8;
    localparam int DEF_LEN_W    = 8;
    localparam int DEF_TICK_DIV = 1024;

    // Bits needed to count 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/note_channel.sv
// One note channel: switch synchroniser, rising-edge trigger, tick prescaler,
// length counter and IDLE/PLAY FSM. NOTE_SUSTAIN_EN enables hold-to-repeat.
module note_channel
    import note_ctrl_pkg::*;
#(
    parameter int FREQ_W   = DEF_FREQ_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              switch_i,
    input  logic [FREQ_W-1:0] freq_cfg_i,
    input  logic [LEN_W-1:0]  len_cfg_i,
    output logic [FREQ_W-1:0] freq_o,
    output logic              active_o,
    output logic              done_o
);

    localparam int             PW   = clog2(TICK_DIV);
    localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

    logic              sync1_q, sync2_q, prev_q, trig_q;
    state_e            state_q, state_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              done_q, done_d;
    logic              wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            trig_q  <= 1'b0;
            state_q <= ST_IDLE;
            freq_q  <= '0;
            len_q   <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= switch_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            trig_q  <= sync2_q & ~prev_q;
            state_q <= state_d;
            freq_q  <= freq_d;
            len_q   <= len_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        len_d   = len_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        wrap    = (presc_q == PMAX);
        case (state_q)
            ST_IDLE: begin
                if (trig_q && len_cfg_i != '0) begin
                    state_d = ST_PLAY;
                    freq_d  = freq_cfg_i;
                    len_d   = len_cfg_i;
                    presc_d = '0;
                end
            end
            ST_PLAY: begin
                // A retrigger wins over a coincident tick wrap.
                if (trig_q) begin
                    if (len_cfg_i != '0) begin
                        freq_d  = freq_cfg_i;
                        len_d   = len_cfg_i;
                        presc_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        freq_d  = '0;
                        len_d   = '0;
                        presc_d = '0;
                    end
                end else begin
                    presc_d = wrap ? '0 : presc_q + PW'(1);
                    if (wrap) begin
`ifdef NOTE_SUSTAIN_EN
                        if (len_q == LEN_W'(1) || !sync2_q) begin
                            done_d = 1'b1;
                            if (sync2_q && len_cfg_i != '0) begin
                                freq_d  = freq_cfg_i;
                                len_d   = len_cfg_i;
                                presc_d = '0;
                            end else begin
                                state_d = ST_IDLE;
                                freq_d  = '0;
                                len_d   = '0;
                                presc_d = '0;
                            end
                        end else begin
                            len_d = len_q - LEN_W'(1);
                        end
`else
                        if (len_q == LEN_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                            freq_d  = '0;
                            len_d   = '0;
                            presc_d = '0;
                        end else begin
                            len_d = len_q - LEN_W'(1);
                        end
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign freq_o   = freq_q;
    assign active_o = (state_q == ST_PLAY);
    assign done_o   = done_q;

endmodule

// File: rtl/note_channel_ctrl.sv
// Multi-channel note controller: NUM_CH independent note channels sharing only
// clock and reset. Build with NOTE_SUSTAIN_EN to enable hold-to-repeat notes.
module note_channel_ctrl
    import note_ctrl_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int FREQ_W   = DEF_FREQ_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        switch,
    input  logic [NUM_CH*FREQ_W-1:0] freq_cfg,
    input  logic [NUM_CH*LEN_W-1:0]  len_cfg,
    output logic [NUM_CH*FREQ_W-1:0] freq,
    output logic [NUM_CH-1:0]        active,
    output logic [NUM_CH-1:0]        done
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        note_channel #(
            .FREQ_W   (FREQ_W),
            .LEN_W    (LEN_W),
            .TICK_DIV (TICK_DIV)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .switch_i   (switch[i]),
            .freq_cfg_i (freq_cfg[i*FREQ_W +: FREQ_W]),
            .len_cfg_i  (len_cfg[i*LEN_W +: LEN_W]),
            .freq_o     (freq[i*FREQ_W +: FREQ_W]),
            .active_o   (active[i]),
            .done_o     (done[i])
        );
    end

endmodule

// File: tb/tb_note_channel_ctrl.sv
// Scoreboard bench for note_channel_ctrl (4 channels, TICK_DIV=4, one-shot build).
module tb_note_channel_ctrl;

    localparam int NCH = 4;
    localparam int FW  = 8;
    localparam int LW  = 8;
    localparam int TD  = 4;

    typedef struct {
        int ch;
        int s;
        int l;
        int f;
    } trig_t;

    typedef struct {
        int ch;
        int c;
    } done_t;

    logic              clk;
    logic              reset_n;
    logic [NCH-1:0]    sw;
    logic [NCH*FW-1:0] fcfg;
    logic [NCH*LW-1:0] lcfg;
    logic [NCH*FW-1:0] freq;
    logic [NCH-1:0]    active;
    logic [NCH-1:0]    done;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 0;
    bit    chk_empty = 0;
    bit    empty_done = 0;
    int    last_chg[NCH];
    trig_t tq[$];
    done_t dq[$];
    int    st[NCH];
    int    en[NCH];
    int    fq[NCH];

    note_channel_ctrl #(
        .NUM_CH   (NCH),
        .FREQ_W   (FW),
        .LEN_W    (LW),
        .TICK_DIV (TD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .switch   (sw),
        .freq_cfg (fcfg),
        .len_cfg  (lcfg),
        .freq     (freq),
        .active   (active),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: a note triggered at edge S with length L owns the
    // interval [S, S+L*TD); its done pulse is seen in the cycle after edge S+L*TD.
    task automatic cancel_done(input int ch);
        for (int i = 0; i < dq.size(); i++) begin
            if (dq[i].ch == ch) begin
                dq.delete(i);
                break;
            end
        end
    endtask

    task automatic apply_trig(input trig_t t);
        bit playing;
        playing = (st[t.ch] < t.s) && (t.s <= en[t.ch]);
        if (t.l == 0) begin
            if (playing) begin
                en[t.ch] = t.s;
                cancel_done(t.ch);
            end
        end else begin
            if (playing) cancel_done(t.ch);
            st[t.ch] = t.s;
            en[t.ch] = t.s + t.l * TD;
            fq[t.ch] = t.f;
            dq.push_back('{ch: t.ch, c: en[t.ch]});
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            st[i] = 0;
            en[i] = 0;
            fq[i] = 0;
        end
    end

    // Monitor: wakes on every falling clock edge and on reset assertion.
    always begin
        @(negedge clk or negedge reset_n);
        #1;
        if (!reset_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                chk($sformatf("reset_freq%0d", ch), int'(freq[ch*FW +: FW]), 0);
                chk($sformatf("reset_active%0d", ch), int'(active[ch]), 0);
                chk($sformatf("reset_done%0d", ch), int'(done[ch]), 0);
            end
        end else if (mon_en) begin
            while (tq.size() > 0 && tq[0].s <= cyc) begin
                apply_trig(tq.pop_front());
            end
            for (int ch = 0; ch < NCH; ch++) begin
                bit exp_act;
                bit exp_done;
                int idx;
                exp_act = (st[ch] <= cyc) && (cyc < en[ch]);
                chk($sformatf("active%0d", ch), int'(active[ch]), int'(exp_act));
                chk($sformatf("freq%0d", ch), int'(freq[ch*FW +: FW]), exp_act ? fq[ch] : 0);
                idx = -1;
                for (int i = 0; i < dq.size(); i++) begin
                    if (dq[i].ch == ch && idx < 0) idx = i;
                end
                exp_done = (idx >= 0) && (dq[idx].c <= cyc);
                chk($sformatf("done%0d", ch), int'(done[ch]), int'(exp_done));
                if (exp_done) dq.delete(idx);
            end
            if (chk_empty && !empty_done) begin
                empty_done = 1;
                chk("pending_done_left", dq.size(), 0);
            end
        end
    end

    task automatic rise(input int ch, input int f, input int l);
        fcfg[ch*FW +: FW] = FW'(f);
        lcfg[ch*LW +: LW] = LW'(l);
        sw[ch] = 1'b1;
        last_chg[ch] = cyc;
        tq.push_back('{ch: ch, s: cyc + 4, l: l, f: f});
    endtask

    task automatic fall(input int ch);
        sw[ch] = 1'b0;
        last_chg[ch] = cyc;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        sw = '0;
        fcfg = '0;
        lcfg = '0;
        for (int i = 0; i < NCH; i++) last_chg[i] = 0;
        wait_cyc(3);
        mon_en = 1;
        reset_n = 1'b1;
        wait_cyc(2);

        // Basic note on channel 0.
        rise(0, 4, 3);
        wait_cyc(5);
        fall(0);
        wait_cyc(20);

        // All channels together, lengths 1..4.
        for (int ch = 0; ch < NCH; ch++) rise(ch, 10 + ch, ch + 1);
        wait_cyc(5);
        for (int ch = 0; ch < NCH; ch++) fall(ch);
        wait_cyc(25);

        // Retrigger on channel 1 ten cycles after the first rise.
        rise(1, 33, 5);
        wait_cyc(4);
        fall(1);
        wait_cyc(6);
        rise(1, 77, 5);
        wait_cyc(4);
        fall(1);
        wait_cyc(30);

        // Zero length: ignored in IDLE, immediate stop during PLAY.
        rise(2, 50, 0);
        wait_cyc(4);
        fall(2);
        wait_cyc(6);
        rise(2, 51, 3);
        wait_cyc(6);
        fall(2);
        wait_cyc(3);
        rise(2, 52, 0);
        wait_cyc(4);
        fall(2);
        wait_cyc(20);

        // Randomised triggers, retriggers and config values.
        for (int it = 0; it < 600; it++) begin
            int ch;
            @(negedge clk);
            ch = int'($urandom_range(0, NCH - 1));
            if (cyc - last_chg[ch] >= 3 && $urandom_range(0, 2) == 0) begin
                if (sw[ch]) fall(ch);
                else rise(ch, int'($urandom_range(0, 255)), int'($urandom_range(0, 4)));
            end
        end
        @(negedge clk);
        sw = '0;
        wait_cyc(40);
        chk_empty = 1;
        wait_cyc(2);

        // Asynchronous reset in the middle of a note.
        rise(0, 99, 10);
        wait_cyc(5);
        fall(0);
        wait_cyc(5);
        @(posedge clk);
        #2;
        mon_en = 0;
        reset_n = 1'b0;
        wait_cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_channel_ctrl.md
Name: note_channel_ctrl

Overview:
Parametrised multi-channel note controller; successor to the fixed 4-switch frequency controller. Each channel turns a switch rising edge into a timed note: it latches a per-channel half-period and length, drives the half-period for exactly that length, then forces zero.
- Sits between board switches / preset table and the waveform generators (sawtooth etc.), which treat half-period 0 as silence.
- Channels are independent; simultaneous triggers are all honoured, with no priority chain.

Parameters:
NUM_CH, 4, number of channels / switches
FREQ_W, 8, half-period width in clock cycles
LEN_W, 8, note length counter width in ticks
TICK_DIV, 1024, clk cycles per length tick (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
switch  in  NUM_CH  raw switch inputs, asynchronous to clk
freq_cfg  in  NUM_CH*FREQ_W  per-channel half-period preset; channel i at [i*FREQ_W +: FREQ_W]
len_cfg  in  NUM_CH*LEN_W  per-channel note length in ticks, same packing
freq  out  NUM_CH*FREQ_W  per-channel half-period to generators; 0 = silent
active  out  NUM_CH  channel currently playing
done  out  NUM_CH  one-cycle pulse when a note ends naturally

Behaviour:
- Reset: async assert clears all state. freq=0, active=0, done=0, synchronisers=0, prescalers=0, length counters=0. Deassert is used synchronously.
- Input path: each switch bit passes a 2-flop synchroniser, then a registered rising-edge detect. A switch rise sampled at clk edge N gives trig[i] high during cycle N+2.
- Per-channel FSM, states IDLE and PLAY:
  - IDLE, trig, len_cfg!=0: latch freq_cfg and len_cfg, clear prescaler, go PLAY. freq/active are valid from edge N+3.
  - IDLE, trig, len_cfg==0: ignored; stay IDLE; no done.
  - PLAY: prescaler counts 0..TICK_DIV-1 and wraps. Each wrap decrements the length counter.
  - PLAY end: on the wrap where the counter is 1, go IDLE, set freq=0 and active=0, pulse done for one cycle. Note lasts exactly len*TICK_DIV cycles.
  - PLAY, trig (retrigger): reload freq/len from the cfg inputs and clear the prescaler. The note restarts from full length; no done pulse. If len_cfg==0 on retrigger, the note stops immediately with no done.
- Config inputs are sampled only on a trigger. Changes during PLAY do not affect the current note.
- A switch fall has no effect unless NOTE_SUSTAIN_EN is defined.
- freq_cfg==0 with len!=0 is legal: the channel is active but silent.
- Width rules: counters are unsigned. The prescaler is ceil(log2(TICK_DIV)) bits. No overflow is possible because the length counter only decrements from a nonzero value.
- Channels share nothing except clk and reset_n.

Optional Feature:
NOTE_SUSTAIN_EN
- Defined: at PLAY end, if the synchronised switch is still high, the note restarts with freshly sampled cfg. In that case done still pulses and active stays 1 (freq stays nonzero if the new cfg is nonzero). A synchronised switch low during PLAY ends the note at the next tick wrap, with a done pulse.
- Undefined: one-shot only, exactly as above. Switch level after the edge is ignored.

Decomposition:
- Package note_ctrl_pkg: state encoding constants (ST_IDLE=1'b0, ST_PLAY=1'b1), default parameter values, function clog2.
- Sub-module note_channel: synchroniser, edge detect, prescaler, length counter and FSM for one channel.
- note_channel_ctrl: generate loop of NUM_CH note_channel instances plus bus slicing.

Test Plan:
All with NUM_CH=4, TICK_DIV=4.
- Reset mid-note: ch0 playing, pull reset_n low asynchronously -> freq=0, active=0, done=0 immediately, without waiting for a clk edge.
- Basic note: freq_cfg[ch0]=4, len_cfg[ch0]=3, raise switch[0] -> freq[ch0]=4 from edge N+3 for exactly 12 cycles, then 0; done[0] high for 1 cycle; active[0] matches.
- Simultaneous: all switches rise together, lens 1/2/3/4 -> all start the same cycle; ends at 4/8/12/16 cycles respectively; other channels unaffected.
- Retrigger: ch1 len=5; re-raise switch[1] after 10 cycles -> note ends 20 cycles after the retrigger start; only one done pulse.
- Zero length: len_cfg[ch2]=0, raise switch[2] -> active[2] stays 0, no done. Retrigger with 0 during PLAY -> immediate stop, no done.
- Sustain (macro defined): ch3 len=2, hold switch[3] -> done every 8 cycles, active stays 1. Release -> note stops at next tick wrap.
